// File: rtl/req_ack_4ph_rx.sv
// Purpose : receive side of a 4-phase req/ack bundled-data link, one-word val/rdy output stage.
// Latency : req pin rise -> ack/val rise after SYNC_STAGES+1 clk_rx edges (buffer free); req fall -> ack fall likewise.
// Backpr. : ack is withheld (FSM parks in HOLD) while the output word is still unaccepted downstream.
//
// Ports:
//   clk_rx   receiver clock
//   rst      asynchronous active-high reset
//   req      request from the transmitter (asynchronous to clk_rx)
//   din      bundled data, stable whenever req is high (never synchronized)
//   ack      registered acknowledge back to the transmitter
//   val      output word valid
//   rdy      downstream ready
//   dout     registered output word
//   err      sticky protocol error (only when REQ_ACK_RX_ERR_EN is defined, else tied 0)
//
// Parameters:
//   DW           data width
//   SYNC_STAGES  depth of the req synchronizer, legal range 2..4
//
// Optional build macro: REQ_ACK_RX_ERR_EN enables the protocol-error detector.
module req_ack_4ph_rx #(
    parameter int DW          = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk_rx,
    input  logic          rst,
    input  logic          req,
    input  logic [DW-1:0] din,
    output logic          ack,
    output logic          val,
    input  logic          rdy,
    output logic [DW-1:0] dout,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            ack_nxt;
    logic            val_nxt;
    logic [DW-1:0]   dout_nxt;
    logic            capture;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    logic                   buf_free;

    // ------------------------------------------------------------------
    // req synchronizer. Only req crosses domains; din is qualified by
    // req_s, by which time the bundled-data rule guarantees it is stable.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_rx or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req};
        end
    end

    assign req_s = sync_q[SYNC_STAGES-1];

    // The stage is free if empty, or if its word is being taken this cycle;
    // the latter lets a new capture replace the old word without a bubble.
    assign buf_free = !val || rdy;

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_rx or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ack   <= 1'b0;
            val   <= 1'b0;
            dout  <= '0;
        end else begin
            state <= state_nxt;
            ack   <= ack_nxt;
            val   <= val_nxt;
            dout  <= dout_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        ack_nxt   = ack;
        capture   = 1'b0;

        case (state)
            IDLE: begin
                ack_nxt = 1'b0;
                if (req_s) begin
                    if (buf_free) begin
                        capture   = 1'b1;
                        state_nxt = ACK;
                    end else begin
                        state_nxt = HOLD;
                    end
                end
            end

            HOLD: begin
                ack_nxt = 1'b0;
                // A withdrawn request must not capture: din is no longer
                // guaranteed stable once req_s has dropped.
                if (!req_s) begin
                    state_nxt = IDLE;
                end else if (buf_free) begin
                    capture   = 1'b1;
                    state_nxt = ACK;
                end
            end

            ACK: begin
                // Stay here for as long as req is held: one word per req phase.
                ack_nxt = 1'b1;
                if (!req_s) begin
                    ack_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end

            default: begin
                ack_nxt   = 1'b0;
                state_nxt = IDLE;
            end
        endcase

        if (capture) begin
            ack_nxt = 1'b1;
        end
    end

    // Output stage: capture wins over a same-cycle accept so val stays high.
    always_comb begin
        val_nxt  = val;
        dout_nxt = dout;
        if (capture) begin
            val_nxt  = 1'b1;
            dout_nxt = din;
        end else if (val && rdy) begin
            val_nxt = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Protocol error detector
    // ------------------------------------------------------------------
`ifdef REQ_ACK_RX_ERR_EN
    logic req_s_d;
    logic hold_drop;
    logic rise_in_ack;

    // Request withdrawn before it was ever acknowledged.
    assign hold_drop   = (state == HOLD) && !req_s;
    // A fresh req rise while ack is still asserted; a compliant
    // transmitter waits for ack to fall before raising req again.
    assign rise_in_ack = req_s && !req_s_d && ack;

    always_ff @(posedge clk_rx or posedge rst) begin
        if (rst) begin
            req_s_d <= 1'b0;
            err     <= 1'b0;
        end else begin
            req_s_d <= req_s;
            if (hold_drop || rise_in_ack) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_req_ack_4ph_rx.sv
module tb_req_ack_4ph_rx;

    localparam int DW = 8;

`ifdef REQ_ACK_RX_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic          clk_rx = 1'b0;
    logic          rst    = 1'b1;
    logic          req    = 1'b0;
    logic [DW-1:0] din    = '0;
    logic          ack;
    logic          val;
    logic          rdy    = 1'b0;
    logic [DW-1:0] dout;
    logic          err;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] exp_q[$];
    int            accepts   = 0;
    int            ack_rises = 0;
    logic          ack_prev  = 1'b0;

    req_ack_4ph_rx #(.DW(DW), .SYNC_STAGES(2)) dut (
        .clk_rx (clk_rx),
        .rst    (rst),
        .req    (req),
        .din    (din),
        .ack    (ack),
        .val    (val),
        .rdy    (rdy),
        .dout   (dout),
        .err    (err)
    );

    always #5 clk_rx = ~clk_rx;

    // Scoreboard: every downstream handshake pops the oldest expected word.
    always @(negedge clk_rx) begin
        if (!rst) begin
            if (ack && !ack_prev) ack_rises++;
            ack_prev = ack;
            if (val && rdy) begin
                accepts++;
                tests++;
                assert (exp_q.size() != 0)
                else begin
                    fails++;
                    $error("FAIL unexpected_word observed=%02h expected=none", dout);
                end
                if (exp_q.size() != 0) begin
                    logic [DW-1:0] e;
                    e = exp_q.pop_front();
                    tests++;
                    assert (dout === e)
                    else begin
                        fails++;
                        $error("FAIL sb_word observed=%02h expected=%02h", dout, e);
                    end
                end
            end
        end else begin
            ack_prev = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_rx);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bounded wait for ack to reach a level; an expired bound is a failure.
    task automatic wait_ack(input string tag, input logic lvl);
        int n;
        n = 0;
        while (ack !== lvl && n < 50) begin
            tick(1);
            n++;
        end
        check(tag, {31'd0, ack}, {31'd0, lvl});
    endtask

    task automatic xfer(input logic [DW-1:0] w);
        din = w;
        req = 1'b1;
        exp_q.push_back(w);
        wait_ack("xfer_ack_hi", 1'b1);
        tick(2);               // transmitter-side synchronizer delay
        req = 1'b0;
        wait_ack("xfer_ack_lo", 1'b0);
        tick(2);
    endtask

    initial begin
        int a0, r0;

        // ---------------- reset state ----------------
        #1;
        check("rst_ack",  ack,  0);
        check("rst_val",  val,  0);
        check("rst_dout", dout, 0);
        check("rst_err",  err,  0);
        tick(2);
        rst = 1'b0;
        tick(1);

        // ---------------- single transfer, exact latency ----------------
        rdy = 1'b1;
        din = 8'hA5;
        req = 1'b1;
        exp_q.push_back(8'hA5);
        tick(2);
        check("single_ack_edge2", ack, 0);
        check("single_val_edge2", val, 0);
        tick(1);
        check("single_ack_edge3",  ack,  1);
        check("single_val_edge3",  val,  1);
        check("single_dout_edge3", dout, 8'hA5);
        req = 1'b0;
        tick(1);
        check("single_val_after_accept", val, 0);
        check("single_ack_hold", ack, 1);
        tick(1);
        check("single_ack_fall_edge2", ack, 1);
        tick(1);
        check("single_ack_fall_edge3", ack, 0);
        tick(2);

        // ---------------- back-pressure ----------------
        rdy = 1'b0;
        xfer(8'h11);
        check("bp_held_val",  val,  1);
        check("bp_held_dout", dout, 8'h11);
        din = 8'h22;
        req = 1'b1;
        exp_q.push_back(8'h22);
        tick(6);
        check("bp_hold_ack",  ack,  0);
        check("bp_hold_dout", dout, 8'h11);
        check("bp_hold_val",  val,  1);
        rdy = 1'b1;
        tick(1);
        check("bp_capture_ack",  ack,  1);
        check("bp_capture_val",  val,  1);
        check("bp_capture_dout", dout, 8'h22);
        tick(2);
        req = 1'b0;
        wait_ack("bp_ack_lo", 1'b0);
        tick(2);

        // ---------------- back-to-back ----------------
        a0 = accepts;
        r0 = ack_rises;
        for (int i = 0; i < 8; i++) xfer(DW'(i));
        check("b2b_accepts",   accepts - a0,   8);
        check("b2b_ack_pairs", ack_rises - r0, 8);
        check("b2b_sb_empty",  exp_q.size(),   0);

        // ---------------- held req ----------------
        a0 = accepts;
        din = 8'h5A;
        req = 1'b1;
        exp_q.push_back(8'h5A);
        wait_ack("held_ack_hi", 1'b1);
        tick(20);
        check("held_ack_stays", ack, 1);
        check("held_one_word",  accepts - a0, 1);
        check("held_val_low",   val, 0);
        req = 1'b0;
        wait_ack("held_ack_lo", 1'b0);
        tick(2);

        // ---------------- reset mid-operation ----------------
        rdy = 1'b0;
        din = 8'h77;
        req = 1'b1;           // abandoned by reset, so nothing is expected
        wait_ack("midrst_ack_hi", 1'b1);
        check("midrst_val_pre", val, 1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_ack",  ack,  0);
        check("midrst_val",  val,  0);
        check("midrst_dout", dout, 0);
        check("midrst_err",  err,  0);
        req = 1'b0;
        tick(2);
        rst = 1'b0;
        rdy = 1'b1;
        tick(1);
        xfer(8'h3C);
        check("midrst_sb_empty", exp_q.size(), 0);

        // ---------------- request withdrawn in HOLD ----------------
        rdy = 1'b0;
        xfer(8'h11);
        din = 8'h22;          // withdrawn: never delivered
        req = 1'b1;
        tick(5);
        check("wd_hold_ack", ack, 0);
        req = 1'b0;
        tick(5);
        check("wd_err",     err, EXP_ERR);
        check("wd_ack_lo",  ack, 0);
        rdy = 1'b1;
        tick(3);
        check("wd_no_word", val, 0);
        check("wd_sb_empty", exp_q.size(), 0);
        tick(5);
        check("wd_err_sticky", err, EXP_ERR);
        xfer(8'h44);          // FSM back in IDLE: a normal transfer completes
        check("wd_final_sb_empty", exp_q.size(), 0);
        check("wd_err_still", err, EXP_ERR);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/req_ack_4ph_rx.md
Name: req_ack_4ph_rx

Overview:
- Receiving end of the 4-phase req/ack bundled-data link; lives in the rx clock domain.
- Synchronizes incoming req, captures the bundled data bus, and returns ack.
- Presents each captured word to local logic through a val/rdy output stage holding one word.
- Back-pressure: ack is withheld while the output stage is full, which stalls the transmitter.

Parameters:
- DW, 8, data width in bits.
- SYNC_STAGES, 2, flops in the req synchronizer chain; legal range 2..4.

Ports:
- clk_rx  input  1  receiver clock
- rst  input  1  reset, asynchronous, active-high
- req  input  1  request from transmitter; asynchronous to clk_rx
- din  input  DW  bundled data; stable whenever req is high
- ack  output  1  acknowledge to transmitter; registered
- val  output  1  output word valid
- rdy  input  1  downstream ready
- dout  output  DW  output word; registered
- err  output  1  sticky protocol error; see Optional Feature

Interface (already decided):
- One clock; reset is asynchronous and active-high.

Behaviour:
- Reset values: ack=0, val=0, dout=0, err=0, all synchronizer flops=0, state=IDLE. Reset mid-handshake abandons the transfer; the transmitter must also be reset.
- req_s = last flop of a SYNC_STAGES chain clocked by clk_rx.
- din is never synchronized. It is sampled only while req_s=1, which is legal by the bundled-data rule.
- buf_free = !val || rdy. This means a word accepted downstream in the same cycle frees the stage.
- Output stage: on val&&rdy with no new capture, val goes to 0 at the next edge. dout holds its value until the next capture.
- FSM states:
  - IDLE, ack=0:
    - req_s && buf_free -> capture: dout<=din, val<=1, ack<=1, go to ACK.
    - req_s && !buf_free -> go to HOLD.
  - HOLD, ack=0:
    - buf_free -> capture as above, go to ACK.
    - !req_s -> go to IDLE; see Optional Feature.
  - ACK, ack=1:
    - !req_s -> ack<=0, go to IDLE.
    - Otherwise hold ack=1. No further capture occurs while in ACK.
- Latency: req rises at the pin -> ack rises after SYNC_STAGES+1 clk_rx edges, when the buffer is free. val rises on the same edge as ack.
- req falls -> ack falls after SYNC_STAGES+1 edges.
- Exactly one capture per req high phase. A req that stays high after ack never produces a second word.
- Simultaneous events: capture on the same edge as downstream accept of the old word is legal. The new word replaces the old one and val stays 1, so no bubble occurs.
- Throughput: at most one word per full 4-phase cycle, about 2*(SYNC_STAGES+1) rx edges plus the transmitter's own synchronizer delay.

Optional Feature:
- Macro: REQ_ACK_RX_ERR_EN.
- With the macro defined:
  - err is set to 1 when req_s falls while the FSM is in HOLD, i.e. the request was withdrawn before ack.
  - err is also set when req_s rises while ack=1, which is impossible for a compliant transmitter.
  - err is sticky until rst. The FSM still returns to IDLE and no word is captured.
- Without the macro: err is tied to 0 and no detection logic is synthesized. All other behaviour is identical.

Test Plan:
- Single transfer, SYNC_STAGES=2, rdy=1: req=1 with din=0xA5 -> ack=1 and val=1 with dout=0xA5 on the 3rd edge. Then req=0 -> ack=0 3 edges later; val drops the cycle after accept.
- Back-pressure: rdy=0, word 0x11 held in the output stage, req=1 with din=0x22 -> state HOLD, ack stays 0, dout stays 0x11. Raise rdy -> 0x11 accepted, 0x22 captured on the same edge, ack=1.
- Back-to-back: 8 transfers 0x00..0x07 driven by a model 4-phase transmitter, rdy=1 -> all 8 words appear in order, no duplicates, ack toggles exactly 8 high/low pairs.
- Held req: req stays high for 20 cycles after ack -> exactly one val pulse and ack stays 1. Then req=0 -> ack=0.
- Reset mid-op: assert rst while in ACK with val=1 -> ack, val, dout, err all 0 immediately (asynchronous). After release, a fresh transfer of 0x3C completes normally.
- REQ_ACK_RX_ERR_EN: in HOLD, drop req before rdy -> err=1 and stays 1. No word is delivered for 0x22, and FSM is in IDLE. Without the macro the same stimulus leaves err=0.
